// File: rtl/instancias_display.sv
// rtl/instancias_display.sv - captures the search instance count, converts it to BCD and drives three 7-segment digits
// Build option LEADING_ZERO_BLANK_EN blanks leading zero digits (hundreds, then tens).
module instancias_display #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cuenta_valid,
  input  logic [WIDTH-1:0] cuenta,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd,
  output logic [6:0]       seg_c,
  output logic [6:0]       seg_d,
  output logic [6:0]       seg_u
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [12+WIDTH-1:0] work;
  logic [2:0]        iter;
  logic [11:0]       adj;
  logic [12+WIDTH-1:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: correct every digit, then shift the whole register left.
  always_comb begin
    adj     = {add3(work[12+WIDTH-1:8+WIDTH]), add3(work[8+WIDTH-1:4+WIDTH]), add3(work[4+WIDTH-1:WIDTH])};
    shifted = {adj[10:0], work[WIDTH-1:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= 12'h000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cuenta_valid) begin
            work  <= {12'h000, cuenta};
            iter  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= shifted;
          iter <= iter + 3'd1;
          if (iter == 3'(ITER - 1)) begin
            bcd   <= shifted[12+WIDTH-1:WIDTH];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign seg_c = (bcd[11:8] == 4'd0) ? 7'b1111111 : seg7(bcd[11:8]);
  assign seg_d = (bcd[11:4] == 8'd0) ? 7'b1111111 : seg7(bcd[7:4]);
`else
  assign seg_c = seg7(bcd[11:8]);
  assign seg_d = seg7(bcd[7:4]);
`endif
  assign seg_u = seg7(bcd[3:0]);

endmodule

// File: tb/tb_instancias_display.sv
// tb/tb_instancias_display.sv - directed self-checking bench for instancias_display
module tb_instancias_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cuenta_valid = 1'b0;
  logic [7:0]  cuenta = 8'd0;
  logic        busy, done;
  logic [11:0] bcd;
  logic [6:0]  seg_c, seg_d, seg_u;

  int total = 0;
  int bad   = 0;

  instancias_display dut (
    .clk(clk), .rst(rst), .cuenta_valid(cuenta_valid), .cuenta(cuenta),
    .busy(busy), .done(done), .bcd(bcd),
    .seg_c(seg_c), .seg_d(seg_d), .seg_u(seg_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'b1000000;  4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;  4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;  4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;  4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;  4'd9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic check_segs(input string tag, input logic [11:0] e);
    logic [6:0] ec, ed;
    ec = pat(e[11:8]);
    ed = pat(e[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (e[11:8] == 4'd0) ec = 7'b1111111;
    if (e[11:4] == 8'd0) ed = 7'b1111111;
`endif
    check({tag, ".seg_c"}, seg_c, ec);
    check({tag, ".seg_d"}, seg_d, ed);
    check({tag, ".seg_u"}, seg_u, pat(e[3:0]));
  endtask

  // Pulse valid before a capture edge, then wait for done; checks latency, hold and result.
  task automatic convert(input string tag, input logic [7:0] val, input logic [11:0] exp_bcd,
                         input logic [11:0] prev_bcd);
    int n;
    bit held;
    @(negedge clk);
    cuenta = val;
    cuenta_valid = 1'b1;
    @(posedge clk); #1;
    cuenta_valid = 1'b0;
    check({tag, ".busy_start"}, busy, 1'b1);
    n = 0;
    held = 1'b1;
    while (!done && n < 20) begin
      if (bcd !== prev_bcd) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, 8);
    check({tag, ".held"}, held, 1'b1);
    check({tag, ".bcd"}, bcd, exp_bcd);
    check({tag, ".busy_end"}, busy, 1'b0);
    check_segs(tag, exp_bcd);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int dones;
    #12;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.bcd", bcd, 12'h000);
    check_segs("rst", 12'h000);
    @(negedge clk);
    rst = 1'b0;

    convert("c0", 8'd0, 12'h000, 12'h000);
    convert("c255", 8'd255, 12'h255, 12'h000);
    check("c255.seg_c_lit", seg_c, 7'b0100100);
    check("c255.seg_u_lit", seg_u, 7'b0010010);
    convert("c100", 8'd100, 12'h100, 12'h255);
    convert("c9", 8'd9, 12'h009, 12'h100);

    // 37 with ignored valid pulses on conversion cycles 3 and 8 (the E8 edge)
    @(negedge clk);
    cuenta = 8'd37;
    cuenta_valid = 1'b1;
    @(posedge clk); #1;
    cuenta_valid = 1'b0;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3 || i == 8) begin
        cuenta = 8'd200;
        cuenta_valid = 1'b1;
      end
      @(posedge clk); #1;
      cuenta_valid = 1'b0;
      if (done) dones++;
    end
    check("ign.done_at_8", done, 1'b1);
    check("ign.bcd", bcd, 12'h037);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("ign.dones", dones, 1);
    check("ign.busy", busy, 1'b0);
    check("ign.bcd_hold", bcd, 12'h037);

    // 123 aborted by async reset in the middle of iteration 4
    @(negedge clk);
    cuenta = 8'd123;
    cuenta_valid = 1'b1;
    @(posedge clk); #1;
    cuenta_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst.busy", busy, 1'b0);
    check("arst.bcd", bcd, 12'h000);
    check_segs("arst", 12'h000);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("arst.no_done", dones, 0);
    convert("c45", 8'd45, 12'h045, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instancias_display.md
Name: instancias_display

Overview:
- Output stage directly downstream of the brute-force pattern search.
- Captures the 8-bit instance count when the search reports completion.
- Converts the count to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives three active-low seven-segment displays (hundreds, tens, units) on the board.

Parameters:
- WIDTH, 8, binary input width; fixed at 8 for this block (3 BCD digits).
- ITER, 8, number of shift iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cuenta_valid  input  1  one-cycle pulse: search finished, cuenta is stable.
- cuenta  input  8  instance count from the search block.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new digits are on the outputs.
- bcd  output  12  {hundreds, tens, units}, 4 bits each.
- seg_c  output  7  hundreds digit segments {g..a}, active-low.
- seg_d  output  7  tens digit segments, active-low.
- seg_u  output  7  units digit segments, active-low.

Behaviour:
- Reset (async, any time, including mid-conversion) clears all state:
  - state=IDLE, busy=0, done=0, bcd=12'h000.
  - seg_c/seg_d/seg_u show "0" (7'b1000000).
  - Shift register and iteration counter are cleared.
  - A conversion in progress is abandoned.
- FSM states: IDLE, SHIFT.
  - IDLE: on the edge E0 where cuenta_valid=1:
    - capture cuenta into a 20-bit working register {bcd_work[11:0], bin[7:0]}, with bcd_work=0.
    - iter=0, busy=1, state=SHIFT.
  - SHIFT: each edge performs one iteration:
    - For each 4-bit digit of bcd_work that is >=5, add 3 (all three digits in parallel, combinational).
    - Then shift the whole 20-bit register left by 1.
    - iter increments.
    - On the 8th iteration edge (E8, iter==7):
      - the result digits are written to the bcd output register.
      - done=1 for exactly that cycle.
      - busy=0, state=IDLE.
- Latency: done is high in the cycle after E8, i.e. 8 clocks after the capture edge.
- bcd and the seg outputs hold their last value until the next done. They never show intermediate values.
- cuenta_valid while busy=1 is ignored. It is not queued.
- cuenta_valid on the same edge as done (E8) is also ignored, because the state is still SHIFT on that edge. A new capture is possible from the next edge.
- cuenta_valid held high in IDLE: recaptures on every edge where the state is IDLE. Each capture runs a full conversion.
- Seg decoders are combinational from the registered bcd digits, so the segments are glitch-free.
  - Digit codes 0-9 map to the standard patterns.
  - Codes 10-15 cannot occur. If they do, decode to all segments off (7'b1111111).
- Arithmetic: the maximum input is 255 -> 2,5,5, so the hundreds digit never exceeds 2. No overflow is possible.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - seg_c is blanked (7'b1111111) when hundreds==0.
  - seg_d is blanked when hundreds==0 and tens==0.
  - Units are always shown.
  - Reset state shows only a units "0".
- Undefined: all three digits are always displayed, including leading zeros.
- bcd output is identical in both builds.

Test Plan:
- Reset, then cuenta=8'd0, pulse valid -> busy high for 8 cycles, done pulse; bcd=12'h000; segs "000" (with LEADING_ZERO_BLANK_EN: blank, blank, "0").
- cuenta=8'd255, pulse valid -> done exactly 8 clocks after the capture edge; bcd=12'h255; seg_c=7'b0100100, seg_d=seg_u=7'b0010010.
- cuenta=8'd100 then, after done, cuenta=8'd9 -> bcd 12'h100 then 12'h009; outputs hold 12'h100 throughout the second conversion until its done.
- Capture 8'd37; pulse valid with cuenta=8'd200 at cycles 3 and 8 (the E8 edge) of the conversion -> both ignored; bcd=12'h037, a single done pulse.
- Capture 8'd123; assert rst asynchronously mid-cycle at iteration 4 -> busy=0 and bcd=0 immediately, no done pulse; a following valid with 8'd45 -> bcd=12'h045.
